// File: rtl/seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : seg_scan_ctrl
// Function : 7-segment digit scan controller with frame-aligned data loading;
//            SEG_SCAN_LZ_BLANK_EN enables leading-zero blanking.
// Revision : 1.0
// ============================================================================
module seg_scan_ctrl #(
  parameter int NUM_DIG = 8,
  parameter int DWELL   = 50000,
  parameter int GAP     = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   load,
  input  logic [4*NUM_DIG-1:0]   data_in,
  input  logic [NUM_DIG-1:0]     dp_in,
  output logic                   load_ack,
  output logic [3:0]             bcd_out,
  output logic                   dp_out,
  output logic [NUM_DIG-1:0]     dig_sel_n,
  output logic                   frame_done
);

  localparam int DW_W = $clog2(DWELL);
  localparam int GP_W = $clog2(GAP + 1);
  localparam int DG_W = $clog2(NUM_DIG);
  localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(DWELL - 1);
  localparam logic [GP_W-1:0] GAP_LAST   = GP_W'(GAP - 1);
  localparam logic [DG_W-1:0] DIG_LAST   = DG_W'(NUM_DIG - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t                    state, state_nx;
  logic [DW_W-1:0]           dwell_cnt;
  logic [GP_W-1:0]           gap_cnt;
  logic [DG_W-1:0]           digit, digit_nx;
  logic [NUM_DIG-1:0][3:0]   shadow;
  logic [NUM_DIG-1:0]        shadow_dp;
  logic                      pending;
  logic                      wait_drop;
  logic                      dwell_end, gap_end, last_dig, frame_end;
  logic                      req, capture, enter_drive;
  logic [3:0]                nib_nx;
  logic [NUM_DIG-1:0]        sel, blank;

  assign dwell_end = (state == S_DRIVE) && (dwell_cnt == DWELL_LAST);
  assign gap_end   = (state == S_GAP) && (gap_cnt == GAP_LAST);
  assign last_dig  = (digit == DIG_LAST);
  assign frame_end = gap_end && last_dig;

  // A captured request is ignored until load drops, so acks never run back to back
  assign req     = load && !wait_drop;
  assign capture = (req || pending) && ((state == S_IDLE) || frame_end);

  assign enter_drive = (state_nx == S_DRIVE) && (state != S_DRIVE);
  assign nib_nx      = capture ? data_in[3:0] : shadow[digit_nx];
  assign sel         = NUM_DIG'(1) << digit;

`ifdef SEG_SCAN_LZ_BLANK_EN
  logic lz_run;
  always_comb begin
    blank  = '0;
    lz_run = 1'b1;
    for (int i = NUM_DIG - 1; i > 0; i--) begin
      lz_run   = lz_run && (shadow[i] == 4'd0) && !shadow_dp[i];
      blank[i] = lz_run;
    end
  end
`else
  assign blank = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    digit_nx = digit;
    case (state)
      S_IDLE: begin
        digit_nx = '0;
        if (en) state_nx = S_DRIVE;
      end
      S_DRIVE: begin
        if (dwell_end) state_nx = S_GAP;
      end
      S_GAP: begin
        if (gap_end) begin
          digit_nx = (last_dig || !en) ? '0 : digit + 1'b1;
          state_nx = en ? S_DRIVE : S_IDLE;
        end
      end
      default: begin
        state_nx = S_IDLE;
        digit_nx = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dwell_cnt  <= '0;
      gap_cnt    <= '0;
      digit      <= '0;
      shadow     <= '0;
      shadow_dp  <= '0;
      pending    <= 1'b0;
      wait_drop  <= 1'b0;
      load_ack   <= 1'b0;
      frame_done <= 1'b0;
      bcd_out    <= 4'd0;
      dp_out     <= 1'b0;
      dig_sel_n  <= '1;
    end else begin
      dwell_cnt  <= (state == S_DRIVE && !dwell_end) ? dwell_cnt + 1'b1 : '0;
      gap_cnt    <= (state == S_GAP && !gap_end) ? gap_cnt + 1'b1 : '0;
      digit      <= digit_nx;
      if (capture) begin
        shadow    <= data_in;
        shadow_dp <= dp_in;
      end
      pending    <= capture ? 1'b0 : (pending || (req && state != S_IDLE));
      wait_drop  <= capture ? 1'b1 : (wait_drop && load);
      load_ack   <= capture;
      frame_done <= frame_end;
      if (enter_drive) bcd_out <= nib_nx;
      // Select and dp trail bcd_out by one cycle to line up with the decoder register
      dig_sel_n  <= (state == S_DRIVE) ? ~(sel & ~blank) : '1;
      dp_out     <= (state == S_DRIVE) && shadow_dp[digit];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_ctrl.sv
`default_nettype none
// Testbench for seg_scan_ctrl (NUM_DIG=4, DWELL=4, GAP=2): table vectors,
// directed corner sequences and randomized traffic against a frame-position model.
module tb_seg_scan_ctrl;

  localparam int N     = 4;
  localparam int DWELL = 4;
  localparam int GAP   = 2;
  localparam int SLOT  = DWELL + GAP;
  localparam int FRAME = N * SLOT;
`ifdef SEG_SCAN_LZ_BLANK_EN
  localparam bit LZ = 1'b1;
`else
  localparam bit LZ = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, en, load;
  logic [15:0]   data_in;
  logic [3:0]    dp_in;
  logic          load_ack, dp_out, frame_done;
  logic [3:0]    bcd_out, dig_sel_n;

  int checks   = 0;
  int failures = 0;

  seg_scan_ctrl #(.NUM_DIG(N), .DWELL(DWELL), .GAP(GAP)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .load       (load),
    .data_in    (data_in),
    .dp_in      (dp_in),
    .load_ack   (load_ack),
    .bcd_out    (bcd_out),
    .dp_out     (dp_out),
    .dig_sel_n  (dig_sel_n),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  // ---------------- reference model: position within the frame ----------------
  bit          m_valid = 1'b0;
  bit          m_active, m_pend, m_wdrop;
  int          m_pos;
  logic [15:0] m_sh;
  logic [3:0]  m_dp;
  logic [3:0]  e_bcd, e_sel;
  bit          e_dp, e_ack, e_fd;

  function automatic bit is_blank(input int d, input logic [15:0] sh, input logic [3:0] dpv);
    int top;
    top = -1;
    for (int i = 0; i < N; i++)
      if (sh[i*4 +: 4] != 4'd0 || dpv[i]) top = i;
    return LZ && (d != 0) && (d > top);
  endfunction

  always @(posedge clk) begin
    int dig, off;
    bit lit, send, fend, req, cap, enter, was_active;
    if (rst) begin
      m_valid = 1'b1; m_active = 1'b0; m_pos = 0; m_sh = '0; m_dp = '0;
      m_pend = 1'b0; m_wdrop = 1'b0;
      e_bcd = 4'd0; e_sel = 4'hF; e_dp = 1'b0; e_ack = 1'b0; e_fd = 1'b0;
    end else begin
      dig  = m_pos / SLOT;
      off  = m_pos % SLOT;
      lit  = m_active && (off < DWELL);
      send = m_active && (off == SLOT - 1);
      fend = send && (dig == N - 1);
      req  = load && !m_wdrop;
      cap  = (req || m_pend) && (!m_active || fend);
      e_sel = (lit && !is_blank(dig, m_sh, m_dp)) ? ~(4'b0001 << dig) : 4'hF;
      e_dp  = lit && m_dp[dig];
      e_ack = cap;
      e_fd  = fend;
      was_active = m_active;
      enter = 1'b0;
      if (!m_active) begin
        if (en) begin m_active = 1'b1; m_pos = 0; enter = 1'b1; end
      end else if (send) begin
        if (en) begin m_pos = (m_pos + 1) % FRAME; enter = 1'b1; end
        else m_active = 1'b0;
      end else begin
        m_pos = m_pos + 1;
      end
      if (enter) e_bcd = cap ? data_in[3:0] : m_sh[(m_pos / SLOT)*4 +: 4];
      if (cap) begin m_sh = data_in; m_dp = dp_in; end
      m_pend  = cap ? 1'b0 : (m_pend || (req && was_active));
      m_wdrop = cap ? 1'b1 : (m_wdrop && load);
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      checks++;
      if ({bcd_out, dp_out, dig_sel_n, load_ack, frame_done} !== {e_bcd, e_dp, e_sel, e_ack, e_fd}) begin
        failures++;
        $display("FAIL model t=%0t bcd=%h/%h dp=%b/%b sel=%b/%b ack=%b/%b fd=%b/%b (got/expected)",
                 $time, bcd_out, e_bcd, dp_out, e_dp, dig_sel_n, e_sel, load_ack, e_ack, frame_done, e_fd);
      end
    end
  end

  // ---------------- directed helpers ----------------
  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_bcd"},  {28'd0, bcd_out}, 32'd0);
    chk({tag, "_dp"},   {31'd0, dp_out}, 32'd0);
    chk({tag, "_sel"},  {28'd0, dig_sel_n}, 32'hF);
    chk({tag, "_ack"},  {31'd0, load_ack}, 32'd0);
    chk({tag, "_fd"},   {31'd0, frame_done}, 32'd0);
  endtask

  typedef struct packed {
    logic [15:0] data;
    logic [3:0]  dp;
    logic [15:0] sel;   // expected lit select per digit, {d3,d2,d1,d0}
  } vec_t;

  vec_t tbl [6];

  initial begin
    rst = 1'b1; en = 1'b0; load = 1'b0; data_in = '0; dp_in = '0;
    tbl[0] = '{16'h4321, 4'b0000, 16'h7BDE};
    tbl[1] = '{16'h9876, 4'b0101, 16'h7BDE};
    tbl[2] = '{16'h0050, 4'b0000, LZ ? 16'hFFDE : 16'h7BDE};
    tbl[3] = '{16'hFA0C, 4'b0000, 16'h7BDE};
    tbl[4] = '{16'h0000, 4'b0100, LZ ? 16'hFBDE : 16'h7BDE};
    tbl[5] = '{16'h0000, 4'b0000, LZ ? 16'hFFFE : 16'h7BDE};

    tick(2);
    chk_reset("reset");
    rst = 1'b0;
    tick(1);

    // Table: load in IDLE, enable, walk one frame
    for (int v = 0; v < 6; v++) begin
      data_in = tbl[v].data; dp_in = tbl[v].dp; load = 1'b1;
      tick(1);
      chk("idle_ack", {31'd0, load_ack}, 32'd1);
      load = 1'b0; en = 1'b1;
      tick(1);
      chk("idle_ack_once", {31'd0, load_ack}, 32'd0);
      for (int d = 0; d < N; d++) begin
        chk($sformatf("v%0d_bcd_d%0d", v, d), {28'd0, bcd_out}, {28'd0, tbl[v].data[d*4 +: 4]});
        tick(2);
        chk($sformatf("v%0d_sel_d%0d", v, d), {28'd0, dig_sel_n}, {28'd0, tbl[v].sel[d*4 +: 4]});
        chk($sformatf("v%0d_dp_d%0d", v, d), {31'd0, dp_out}, {31'd0, tbl[v].dp[d]});
        tick(4);
      end
      chk("frame_done", {31'd0, frame_done}, 32'd1);
      en = 1'b0;
      tick(8);
      chk("idle_sel", {28'd0, dig_sel_n}, 32'hF);
    end

    // Load during digit 1: capture only at frame end
    data_in = 16'h4321; dp_in = '0; load = 1'b1;
    tick(1);
    load = 1'b0; en = 1'b1;
    tick(1);                        // X: digit 0 entry
    tick(7);
    data_in = 16'h9876; load = 1'b1;
    tick(5);
    chk("old_d2", {28'd0, bcd_out}, 32'd3);
    tick(6);
    chk("old_d3", {28'd0, bcd_out}, 32'd4);
    tick(5);                        // X+23: frame-end cycle
    chk("ack_before_end", {31'd0, load_ack}, 32'd0);
    chk("fd_before_end", {31'd0, frame_done}, 32'd0);
    tick(1);                        // X+24
    chk("ack_after_end", {31'd0, load_ack}, 32'd1);
    chk("fd_period1", {31'd0, frame_done}, 32'd1);
    chk("new_d0", {28'd0, bcd_out}, 32'd6);
    load = 1'b0;
    tick(1);
    chk("ack_single", {31'd0, load_ack}, 32'd0);
    chk("fd_single", {31'd0, frame_done}, 32'd0);
    tick(5);
    chk("new_d1", {28'd0, bcd_out}, 32'd7);
    tick(6);
    chk("new_d2", {28'd0, bcd_out}, 32'd8);
    tick(6);
    chk("new_d3", {28'd0, bcd_out}, 32'd9);
    tick(6);                        // Y = X+48
    chk("fd_period2", {31'd0, frame_done}, 32'd1);
    chk("no_extra_ack", {31'd0, load_ack}, 32'd0);

    // en drop mid digit 2
    tick(13);
    en = 1'b0;
    tick(2);
    chk("d2_finishes", {28'd0, dig_sel_n}, 32'hB);
    for (int k = 16; k <= 30; k++) begin
      tick(1);
      chk("en_drop_fd", {31'd0, frame_done}, 32'd0);
      if (k >= 17) chk("en_drop_sel", {28'd0, dig_sel_n}, 32'hF);
    end

    // Reset during GAP with a pending load
    data_in = 16'h1234; load = 1'b1;
    tick(1);
    load = 1'b0; en = 1'b1;
    tick(1);                        // Z
    tick(1);
    data_in = 16'hABCD; load = 1'b1;
    tick(3);
    rst = 1'b1; load = 1'b0;
    tick(1);
    chk_reset("gap_rst");
    rst = 1'b0; en = 1'b0;
    for (int k = 0; k < 30; k++) begin
      tick(1);
      chk("no_ack_after_rst", {31'd0, load_ack}, 32'd0);
    end
    en = 1'b1;
    tick(1);
    chk("shadow_cleared", {28'd0, bcd_out}, 32'd0);

    // Randomized traffic, checked by the model every cycle
    for (int c = 0; c < 3000; c++) begin
      if (load && load_ack) load = 1'b0;
      else if (!load && $urandom_range(0, 15) == 0) begin
        data_in = 16'($urandom);
        dp_in   = 4'($urandom);
        load    = 1'b1;
      end
      if ($urandom_range(0, 39) == 0) en = ~en;
      rst = ($urandom_range(0, 499) == 0);
      tick(1);
    end
    rst = 1'b0; en = 1'b0; load = 1'b0;
    tick(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
